fifo_wr_arbiter: RTL and testbench

- Shares one 16-entry byte FIFO (wen/ren, full/empty, overwrite-on-full semantics) between NUM_REQ producers and one consumer.
- Round-robin write arbitration with packet lock: a granted producer keeps the write port until its beat marked last is accepted.
- Gates all FIFO writes on full and all reads on empty, so the FIFO overwrite and underfill paths are never exercised.
- Sits between producer logic and the fifo instance; all FIFO control inputs come from this block.

---
 rtl/fifo_arb_pkg.sv | 36 +++
 rtl/fifo_wr_arbiter_if.sv | 39 +++
 rtl/rr_select.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 101 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin pick function for the FIFO write arbiter.
// rr_pick works on a fixed 8-wide vector so every producer count from 2 to 8 shares one implementation.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int MAX_REQ = 8;
    localparam int PICK_W  = 3;

    // First set bit of valid at or after ptr, wrapping modulo n; returns 0 when nothing is set.
    function automatic logic [PICK_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [PICK_W-1:0]  ptr,
        input int                 n
    );
        logic [PICK_W-1:0] sel;
        logic [PICK_W-1:0] pos;
        logic              found;
        int                idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % n;
            pos = PICK_W'(idx);
            if (k < n && !found && valid[pos]) begin
                sel   = pos;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer, FIFO-control and consumer signals of the arbiter bundled into one interface.
// slave is the arbiter's view; master is the surrounding producers, FIFO and consumer.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic [ID_W-1:0]           gnt_id;
    logic                      busy;
    logic                      fifo_wen;
    logic [DATA_W-1:0]         fifo_wdata;
    logic                      fifo_ren;
    logic [DATA_W-1:0]         fifo_rdata;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      rd_req;
    logic                      rd_valid;
    logic [DATA_W-1:0]         rd_data;

    modport slave (
        input  req_valid, req_data, req_last,
        input  fifo_rdata, fifo_full, fifo_empty, rd_req,
        output req_ready, gnt_id, busy,
        output fifo_wen, fifo_wdata, fifo_ren,
        output rd_valid, rd_data
    );

    modport master (
        output req_valid, req_data, req_last,
        output fifo_rdata, fifo_full, fifo_empty, rd_req,
        input  req_ready, gnt_id, busy,
        input  fifo_wen, fifo_wdata, fifo_ren,
        input  rd_valid, rd_data
    );
endinterface

// File: rtl/rr_select.sv
// Combinational round-robin picker: lowest requester index at or after ptr, modulo NUM_REQ.
module rr_select
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);

    logic [MAX_REQ-1:0] valid_ext;
    logic [PICK_W-1:0]  ptr_ext;

    generate
        for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_ext
            if (gi < NUM_REQ) begin : g_live
                assign valid_ext[gi] = valid[gi];
            end else begin : g_pad
                assign valid_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign ptr_ext = PICK_W'(ptr);
    assign idx     = PTR_W'(rr_pick(valid_ext, ptr_ext, NUM_REQ));
    assign any     = |valid;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked write arbiter in front of a shared byte FIFO, plus a one-stage pop path.
// Writes are blocked while full and reads while empty, so the FIFO never overwrites or underflows.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 2
) (
    input  logic            clk,
    input  logic            rst,
    fifo_wr_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_e        state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic [PTR_W-1:0]  pick_idx;
    logic              pick_any;
    logic [PTR_W-1:0]  gnt;
    logic              accept;
    logic              ren;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_select (
        .valid (bus.req_valid),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        gnt        = owner_q;
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;

        // With nobody requesting in IDLE, gnt stays on the previous owner so gnt_id reports it.
        if (state_q == IDLE && pick_any) begin
            gnt = pick_idx;
        end

        accept = !rst && bus.req_valid[gnt] && !bus.fifo_full;
        ren    = !rst && bus.rd_req && !bus.fifo_empty;

        if (accept) begin
            owner_d = gnt;
            if (bus.req_last[gnt]) begin
                state_d  = IDLE;
                rr_ptr_d = (gnt == PTR_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
            end else begin
                state_d = LOCK;
            end
        end

        if (ren) begin
            rd_valid_d = 1'b1;
            rd_data_d  = bus.fifo_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign bus.req_ready[gi] = accept && (gnt == PTR_W'(gi));
        end
    endgenerate

    assign bus.fifo_wen   = accept;
    assign bus.fifo_wdata = bus.req_data[gnt*DATA_W +: DATA_W];
    assign bus.fifo_ren   = ren;
    assign bus.gnt_id     = ID_W'(gnt);
    assign bus.busy       = (state_q == LOCK);
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_data_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised and directed bench for fifo_wr_arbiter against a packet/queue-level reference model.
// A 16-slot pointer FIFO (15 usable entries) stands in for the real FIFO instance.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;
    localparam int CAP = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ID_W(IW)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ID_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stand-in FIFO, reset from rst_n = ~rst.
    logic       rst_n;
    logic [7:0] fmem [16];
    logic [3:0] fw, fr;
    int         fcount;
    assign rst_n = ~rst;
    always @(posedge clk) begin
        if (!rst_n) begin
            fw <= '0;
            fr <= '0;
            fcount <= 0;
        end else begin
            if (bus.fifo_wen && fcount < CAP) begin
                fmem[fw] <= bus.fifo_wdata;
                fw <= fw + 4'd1;
            end
            if (bus.fifo_ren && fcount > 0) fr <= fr + 4'd1;
            fcount <= fcount + ((bus.fifo_wen && fcount < CAP) ? 1 : 0)
                             - ((bus.fifo_ren && fcount > 0) ? 1 : 0);
        end
    end
    assign bus.fifo_full  = (fcount == CAP);
    assign bus.fifo_empty = (fcount == 0);
    assign bus.fifo_rdata = fmem[fr];

    // Stimulus state
    logic [N-1:0] drv_valid = '0;
    logic [N-1:0] drv_last  = '0;
    logic         drv_rd    = 1'b0;
    logic [7:0]   pdata [N];
    bit           auto_inc  = 1'b0;

    // Reference model state
    bit         locked;
    int         rr_ptr, owner;
    logic [7:0] exp_q [$];
    bit         exp_rdv;
    logic [7:0] exp_rdd;
    int         wr_count = 0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive, predict and compare at the falling edge, advance the model, cross the rising edge.
    task automatic step();
        int           g;
        bit           acc, ren;
        logic [N-1:0] exp_ready;
        bus.req_valid = drv_valid;
        bus.req_last  = drv_last;
        bus.rd_req    = drv_rd;
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = pdata[i];
        @(negedge clk);
        if (rst) begin
            locked = 0; rr_ptr = 0; owner = 0;
            exp_q.delete(); exp_rdv = 0; exp_rdd = '0;
        end else begin
            check("busy", bus.busy, locked);
            check("rd_valid", bus.rd_valid, exp_rdv);
            if (exp_rdv) check("rd_data", bus.rd_data, exp_rdd);
            check("fifo_full", bus.fifo_full, exp_q.size() == CAP);
            check("fifo_empty", bus.fifo_empty, exp_q.size() == 0);

            g = -1;
            if (locked) g = owner;
            else for (int k = 0; k < N; k++)
                if (g < 0 && drv_valid[(rr_ptr + k) % N]) g = (rr_ptr + k) % N;
            acc = (g >= 0) && drv_valid[g] && (exp_q.size() < CAP);
            exp_ready = '0;
            if (acc) exp_ready[g] = 1'b1;
            check("req_ready", bus.req_ready, exp_ready);
            check("fifo_wen", bus.fifo_wen, acc);
            check("gnt_id", bus.gnt_id, (g >= 0) ? g : owner);
            if (acc) check("fifo_wdata", bus.fifo_wdata, pdata[g]);
            ren = drv_rd && exp_q.size() > 0;
            check("fifo_ren", bus.fifo_ren, ren);

            exp_rdv = ren;
            if (ren) begin
                exp_rdd = exp_q.pop_front();
                $display("RD  t=%0t data=%02h", $time, exp_rdd);
            end
            if (acc) begin
                exp_q.push_back(pdata[g]);
                wr_count++;
                $display("WR  t=%0t prod=%0d data=%02h last=%0d", $time, g, pdata[g], drv_last[g]);
                owner = g;
                if (drv_last[g]) begin
                    locked = 0;
                    rr_ptr = (g + 1) % N;
                end else begin
                    locked = 1;
                end
                if (auto_inc) pdata[g] = pdata[g] + 8'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drv_valid = '0; drv_last = '0; drv_rd = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    int base;
    logic [7:0] beats [3];

    initial begin
        for (int i = 0; i < N; i++) pdata[i] = '0;
        do_reset();
        step();
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_gnt_id", bus.gnt_id, 0);

        // Single-beat round robin, all producers always valid.
        for (int i = 0; i < N; i++) pdata[i] = 8'hA0 + 8'(i);
        drv_valid = '1; drv_last = '1;
        for (int c = 0; c < 8; c++) step();
        check("rr_fifo_head", fmem[0], 8'hA0);
        check("rr_fifo_5th", fmem[4], 8'hA0);

        // Packet lock: producer 2 sends three beats while producer 0 also requests.
        do_reset();
        beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
        drv_valid = 4'b0100; drv_last = 4'b0001;
        for (int b = 0; b < 3; b++) begin
            pdata[2] = beats[b];
            drv_last[2] = (b == 2);
            step();
            drv_valid[0] = 1'b1;
        end
        check("lock_beats", wr_count >= 3 ? fmem[2] : 8'h00, 8'h33);
        drv_valid = '0;
        step();

        // Full stall: producer 1 streams a long packet with the consumer idle.
        do_reset();
        auto_inc = 1'b1; pdata[1] = 8'h40;
        drv_valid = 4'b0010; drv_last = '0;
        base = wr_count;
        for (int c = 0; c < 20; c++) step();
        check("full_writes", wr_count - base, CAP);
        drv_rd = 1'b1; step();
        drv_rd = 1'b0; step();
        step();
        check("full_after_pop", wr_count - base, CAP + 1);

        // Empty pop: no read enable, no read data, write pointer untouched.
        do_reset();
        drv_valid = '0; drv_rd = 1'b1;
        for (int c = 0; c < 3; c++) step();
        check("empty_wptr", fw, 0);
        drv_rd = 1'b0; drv_valid = 4'b0001; drv_last = 4'b0001; pdata[0] = 8'h5C;
        step();
        drv_valid = '0; drv_rd = 1'b1; step();
        drv_rd = 1'b0; step();

        // Concurrent read and write at a steady occupancy of five.
        do_reset();
        drv_valid = 4'b1000; drv_last = 4'b1000; pdata[3] = 8'hC0;
        for (int c = 0; c < 5; c++) step();
        drv_rd = 1'b1;
        for (int c = 0; c < 10; c++) step();
        check("conc_count", fcount, 5);
        drv_valid = '0; drv_rd = 1'b0; step();

        // Reset in the middle of a locked packet.
        do_reset();
        drv_valid = 4'b0100; drv_last = '0;
        step(); step();
        check("mid_busy", bus.busy, 1);
        do_reset();
        drv_valid = 4'b0001; drv_last = 4'b0001;
        step();
        check("mid_empty_first", fcount, 1);

        // Randomised traffic with occasional resets.
        for (int c = 0; c < 500; c++) begin
            drv_valid = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) drv_last[i] = ($urandom_range(0, 2) == 0);
            drv_rd = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1; step(); rst = 1'b0;
            end else begin
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
